// File: rtl/sysbus_mem_responder_pkg.sv
// Shared definitions for the Sysbus memory responder: FSM states, tag layout,
// transaction type codes and line geometry.
package sysbus_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2,
        ST_WR_DATA = 2'd3
    } state_t;

    localparam int TAG_RW_BIT   = 12;
    localparam int TAG_TYPE_MSB = 11;
    localparam int TAG_TYPE_LSB = 8;

    localparam logic [3:0] TYPE_MEMORY = 4'b0001;
    localparam logic       RW_READ     = 1'b1;
    localparam logic       RW_WRITE    = 1'b0;

    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);
    // A line is BEATS_PER_LINE words of 8 bytes, so this many low address bits are the byte offset.
    localparam int LINE_OFS_W     = BEAT_W + 3;

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing store for the responder: one synchronous write port and one
// asynchronous read port.
module sysbus_mem_array #(
    parameter int WORDS  = 4096,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [WORDS];

    // Contents are deliberately not reset so data survives a bus reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus slave that serves 64-byte line reads and writes from a local memory,
// one outstanding transaction at a time.
module sysbus_mem_responder
    import sysbus_mem_responder_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output state_t                    o_dbg_state
);

    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    // Handshake: a request beat transfers in any cycle where bus_reqcyc and
    // bus_reqack are both high; a response beat transfers in any cycle where
    // bus_respcyc and bus_respack are both high. Neither side waits a cycle.

    state_t                     r_state;
    logic [BEAT_W-1:0]          r_beat;
    logic [LAT_W-1:0]           r_lat;
    logic [BUS_TAG_WIDTH-1:0]   r_tag;
    logic [AW-1:0]              r_index;

    logic [AW-1:0]              w_line_idx;
    logic [AW-1:0]              w_mem_addr;
    logic [BUS_DATA_WIDTH-1:0]  w_rdata;
    logic                       w_req_is_mem;
    logic                       w_we;
    logic                       w_resp_active;
    logic                       w_last_beat;

    // Line base >> 3, truncated to the memory depth: upper address bits wrap silently.
    assign w_line_idx    = {bus_req[AW+2:LINE_OFS_W], {BEAT_W{1'b0}}};
    assign w_mem_addr    = r_index + AW'(r_beat);
    assign w_req_is_mem  = (bus_reqtag[TAG_TYPE_MSB:TAG_TYPE_LSB] == TYPE_MEMORY);
    assign w_last_beat   = (r_beat == BEAT_W'(BEATS_PER_LINE - 1));

    assign bus_reqack    = !reset && bus_reqcyc &&
                           (r_state == ST_IDLE || r_state == ST_WR_DATA);
    assign w_we          = !reset && bus_reqcyc && (r_state == ST_WR_DATA);
    assign w_resp_active = !reset && (r_state == ST_RD_RESP);

    assign bus_respcyc   = w_resp_active;
    assign bus_resp      = w_resp_active ? w_rdata : '0;
    assign bus_resptag   = w_resp_active ? r_tag : '0;
    assign o_dbg_state   = r_state;

    sysbus_mem_array #(
        .WORDS  (MEM_WORDS),
        .DATA_W (BUS_DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_mem_addr),
        .i_wdata (bus_req),
        .i_raddr (w_mem_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
            r_lat   <= '0;
            r_tag   <= '0;
            r_index <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_reqcyc) begin
                        r_tag   <= bus_reqtag;
                        r_index <= w_line_idx;
                        r_beat  <= '0;
                        if (w_req_is_mem && bus_reqtag[TAG_RW_BIT] == RW_READ) begin
                            r_lat <= LAT_W'(READ_LATENCY - 1);
                            // The ack cycle counts toward the latency, so a latency of 1 skips the wait.
                            r_state <= (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
                        end else if (w_req_is_mem && bus_reqtag[TAG_RW_BIT] == RW_WRITE) begin
                            r_state <= ST_WR_DATA;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    r_lat <= r_lat - 1'b1;
                    if (r_lat == LAT_W'(1)) begin
                        r_state <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (bus_respack) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (bus_reqcyc) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Bench for sysbus_mem_responder: directed line reads/writes plus randomized
// traffic, checked by a response monitor against a word-array memory model.
module tb_sysbus_mem_responder;
    import sysbus_mem_responder_pkg::*;

    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int MW  = 4096;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic          bus_reqack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respcyc;
    logic          bus_respack;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    state_t        dbg_state;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (MW),
        .READ_LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model and scoreboard ----------------
    logic [DW-1:0] ref_mem   [MW];
    bit            ref_known [MW];
    logic [DW-1:0] exp_q[$];
    logic [TW-1:0] exp_tag_q[$];
    bit            exp_known_q[$];

    int   checks  = 0;
    int   errors  = 0;
    int   bp_mode = 0;
    logic man_ack = 1'b1;

    function automatic int line_word(input logic [63:0] addr);
        longint unsigned a;
        a = addr;
        return int'(((a / 64) * 8) % MW);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, want DUT event", name);
    endtask

    task automatic push_read(input logic [63:0] addr, input logic [TW-1:0] tag);
        int w;
        w = line_word(addr);
        for (int b = 0; b < BEATS_PER_LINE; b++) begin
            exp_q.push_back(ref_mem[(w + b) % MW]);
            exp_tag_q.push_back(tag);
            exp_known_q.push_back(ref_known[(w + b) % MW]);
        end
    endtask

    // ---------------- response monitor ----------------
    logic [DW-1:0] hold_data;
    logic [TW-1:0] hold_tag;
    bit            hold_pending = 0;
    logic [DW-1:0] mon_d;
    logic [TW-1:0] mon_t;
    bit            mon_k;

    always @(negedge clk) begin
        if (!bus_respcyc) begin
            hold_pending = 0;
            check("idle_resp_zero", bus_resp, 64'd0);
            check("idle_resptag_zero", 64'(bus_resptag), 64'd0);
        end else begin
            if (hold_pending) begin
                check("hold_data", bus_resp, hold_data);
                check("hold_tag", 64'(bus_resptag), 64'(hold_tag));
            end
            if (bus_respack) begin
                hold_pending = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h tag %h, want no beat", bus_resp, bus_resptag);
                end else begin
                    mon_d = exp_q.pop_front();
                    mon_t = exp_tag_q.pop_front();
                    mon_k = exp_known_q.pop_front();
                    if (mon_k) check("beat_data", bus_resp, mon_d);
                    check("beat_tag", 64'(bus_resptag), 64'(mon_t));
                end
            end else begin
                hold_pending = 1;
                hold_data    = bus_resp;
                hold_tag     = bus_resptag;
            end
        end
    end

    // ---------------- response-ack driver ----------------
    initial begin
        bus_respack = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus_respack = 1'b1;
                1:       bus_respack = 1'($urandom_range(0, 1));
                default: bus_respack = man_ack;
            endcase
        end
    end

    // ---------------- request driver tasks ----------------
    task automatic send_req(input logic [63:0] addr, input logic [TW-1:0] tag,
                            input bit must_now, output int waited);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        waited     = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus_reqack && waited < 200);
        if (!bus_reqack) fail_timeout("req_ack");
        else if (must_now) check("req_ack_same_cycle", 64'(waited), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_read_latency();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_respcyc && n < 200);
        check("read_latency", 64'(n), 64'(LAT));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_respcyc) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || bus_respcyc) fail_timeout("read_drain");
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] id);
        int w;
        logic [TW-1:0] tag;
        tag = {RW_READ, TYPE_MEMORY, id};
        push_read(addr, tag);
        send_req(addr, tag, 1, w);
        bus_reqcyc = 1'b0;
        check_read_latency();
        wait_done();
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [7:0] id, input bit rnd,
                            input logic [63:0] d0, input bit gaps);
        int w;
        int base;
        logic [63:0] d;
        base = line_word(addr);
        send_req(addr, {RW_WRITE, TYPE_MEMORY, id}, 1, w);
        for (int b = 0; b < BEATS_PER_LINE; b++) begin
            if (gaps) begin
                bus_reqcyc = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            d = rnd ? {$urandom, $urandom} : d0 + 64'(b);
            bus_reqcyc = 1'b1;
            bus_req    = d;
            @(negedge clk);
            check("wr_beat_ack", 64'(bus_reqack), 64'd1);
            ref_mem[(base + b) % MW]   = d;
            ref_known[(base + b) % MW] = 1;
            @(posedge clk);
            #1;
        end
        bus_reqcyc = 1'b0;
    endtask

    task automatic do_unsupported(input logic [63:0] addr, input logic [3:0] typ, input logic [7:0] id);
        int w;
        send_req(addr, {1'($urandom_range(0, 1)), typ, id}, 1, w);
        bus_reqcyc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("unsup_no_resp", 64'(bus_respcyc), 64'd0);
            check("unsup_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish within bound");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    logic [63:0] pool [8];
    logic [TW-1:0] tag_a;
    logic [TW-1:0] tag_b;
    logic [63:0] exp2;
    logic [63:0] addr;
    logic [3:0]  typ;
    int          w;
    int          op;

    initial begin
        pool[0] = 64'h1000; pool[1] = 64'h2040; pool[2] = 64'h0000; pool[3] = 64'h7FC0;
        pool[4] = 64'h4000; pool[5] = 64'h1A80; pool[6] = 64'h3F00; pool[7] = 64'h0C40;

        reset      = 1'b1;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        repeat (2) @(posedge clk);
        #1;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h1000;
        bus_reqtag = 13'h1105;
        @(negedge clk);
        check("reset_reqack", 64'(bus_reqack), 64'd0);
        check("reset_respcyc", 64'(bus_respcyc), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus_reqcyc = 1'b0;

        // Line at 0x1000 (words 0x200..0x207), then read it back with tag 0x1105.
        do_write(64'h1000, 8'h01, 0, 64'h1111_0000, 0);
        do_read(64'h1000, 8'h05);

        // Write 0xA0..0xA7 then read in the very next cycle.
        do_write(64'h2040, 8'h02, 0, 64'hA0, 0);
        do_read(64'h2040, 8'h03);

        // Unaligned address above the memory size aliases to word 0.
        do_write(64'h0000, 8'h04, 1, 64'd0, 1);
        do_read(64'h803F, 8'h06);
        do_read(64'h0000, 8'h07);

        // Hold respack low for three cycles on beat 2.
        bp_mode = 2;
        man_ack = 1'b1;
        tag_a   = {RW_READ, TYPE_MEMORY, 8'h08};
        push_read(64'h2040, tag_a);
        exp2 = ref_mem[(line_word(64'h2040) + 2) % MW];
        send_req(64'h2040, tag_a, 1, w);
        bus_reqcyc = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        man_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) man_ack = 1'b1;
            @(negedge clk);
            check("bp_beat2_held", bus_resp, exp2);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        wait_done();
        bp_mode = 0;

        // Request held during a read: must not be acked until the read finishes.
        tag_a = {RW_READ, TYPE_MEMORY, 8'h10};
        tag_b = {RW_READ, TYPE_MEMORY, 8'h11};
        push_read(64'h1000, tag_a);
        send_req(64'h1000, tag_a, 1, w);
        push_read(64'h2040, tag_b);
        send_req(64'h2040, tag_b, 0, w);
        check("busy_ack_delay", 64'(w), 64'(LAT + BEATS_PER_LINE));
        bus_reqcyc = 1'b0;
        check_read_latency();
        wait_done();

        // Unsupported type is acked and dropped.
        do_unsupported(64'h1000, 4'b0011, 8'h20);
        do_read(64'h1000, 8'h21);

        // Reset during beat 3 of a read, with the next read already waiting.
        tag_a = {RW_READ, TYPE_MEMORY, 8'h30};
        push_read(64'h2040, tag_a);
        send_req(64'h2040, tag_a, 1, w);
        bus_reqcyc = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_tag_q.delete();
        exp_known_q.delete();
        tag_b      = {RW_READ, TYPE_MEMORY, 8'h31};
        bus_reqcyc = 1'b1;
        bus_req    = 64'h2040;
        bus_reqtag = tag_b;
        @(negedge clk);
        check("midreset_respcyc", 64'(bus_respcyc), 64'd0);
        check("midreset_reqack", 64'(bus_reqack), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_read(64'h2040, tag_b);
        @(negedge clk);
        check("post_reset_ack", 64'(bus_reqack), 64'd1);
        check("post_reset_respcyc", 64'(bus_respcyc), 64'd0);
        @(posedge clk);
        #1;
        bus_reqcyc = 1'b0;
        check_read_latency();
        wait_done();

        // Randomized traffic over a pool of lines and their address aliases.
        for (int i = 0; i < 8; i++) do_write(pool[i], 8'(8'h40 + i), 1, 64'd0, 1);
        for (int i = 0; i < 40; i++) begin
            addr = pool[$urandom_range(0, 7)] + 64'($urandom_range(0, 3)) * 64'h8000
                   + 64'($urandom_range(0, 63));
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_write(addr, 8'(i), 1, 64'd0, 1'($urandom_range(0, 1)));
            end else if (op < 9) begin
                bp_mode = $urandom_range(0, 1);
                do_read(addr, 8'(i));
                bp_mode = 0;
            end else begin
                typ = 4'($urandom_range(0, 14));
                if (typ >= 4'd1) typ = typ + 4'd1;
                do_unsupported(addr, typ, 8'(i));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 Parameters SHALL be: BUS_DATA_WIDTH, default 64, bus data width; BUS_TAG_WIDTH, default 13, tag width; MEM_WORDS, default 4096, backing store depth in 64-bit words (power of two); READ_LATENCY, default 4, cycles from request ack to first response beat (>=1).
REQ-002 Port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port bus_reqcyc, input, 1: initiator has a valid request beat on bus_req/bus_reqtag.
REQ-005 Port bus_reqack, output, 1: responder accepts the current request beat this cycle.
REQ-006 Port bus_req, input, BUS_DATA_WIDTH: address beat (byte address) or write data beat.
REQ-007 Port bus_reqtag, input, BUS_TAG_WIDTH: tag; [12]=1 read / 0 write, [11:8] type (MEMORY=4'b0001), [7:0] id.
REQ-008 Port bus_respcyc, output, 1: a valid response beat is on bus_resp/bus_resptag.
REQ-009 Port bus_respack, input, 1: initiator consumes the current response beat this cycle.
REQ-010 Port bus_resp, output, BUS_DATA_WIDTH: read data beat.
REQ-011 Port bus_resptag, output, BUS_TAG_WIDTH: echo of the originating request tag.

Function
REQ-012 The block SHALL implement the slave end of the Sysbus: one outstanding transaction, 64-byte lines, 8 beats of 64 bits.
REQ-013 States SHALL be IDLE, RD_WAIT, RD_RESP, WR_DATA.
REQ-014 In IDLE with bus_reqcyc=1, bus_reqack SHALL be 1 in that same cycle (combinational from state and bus_reqcyc), and address and tag SHALL be latched; line base = bus_req with [5:0] cleared; word index = (base>>3) mod MEM_WORDS (silent wrap, no error).
REQ-015 If the latched tag has [12]=1 and [11:8]=MEMORY: IDLE->RD_WAIT; latency counter loads READ_LATENCY-1; RD_WAIT->RD_RESP when the counter reaches 0, so the first beat appears exactly READ_LATENCY cycles after the ack cycle.
REQ-016 In RD_RESP, bus_respcyc SHALL be 1, bus_resp SHALL be word (index+beat) mod MEM_WORDS, and bus_resptag SHALL be the latched tag; beat (0..7) SHALL advance only in a cycle with bus_respack=1; data SHALL be held stable while respack=0.
REQ-017 Acking beat 7 SHALL return the state to IDLE with bus_respcyc=0 on the next cycle; a new request SHALL NOT be acked earlier than that IDLE cycle.
REQ-018 If the latched tag has [12]=0 and [11:8]=MEMORY: IDLE->WR_DATA; each cycle with bus_reqcyc=1 SHALL be acked in that same cycle and bus_req written to word (index+beat) mod MEM_WORDS; the 8th acked beat SHALL return the state to IDLE; no response beats SHALL be issued for writes.
REQ-019 Gaps (bus_reqcyc=0) in WR_DATA SHALL stall the beat counter without timeout.
REQ-020 A request with any type other than MEMORY SHALL be acked and dropped: the block remains in IDLE and produces no response.
REQ-021 bus_reqack SHALL be 0 in RD_WAIT and RD_RESP regardless of bus_reqcyc.
REQ-022 Outside RD_RESP, bus_respcyc SHALL be 0, bus_resp SHALL be 0, and bus_resptag SHALL be 0.
REQ-023 A read issued in the cycle immediately after a write's 8th beat SHALL return the newly written data (write-before-read ordering).

Reset
REQ-024 While reset=1: state SHALL be IDLE, beat and latency counters 0, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no further beats; words already written SHALL stay written; memory contents SHALL NOT be cleared by reset.

Structure
REQ-026 A shared package SHALL hold the state enum, tag field positions, the MEMORY type code, READ/WRITE bit values, and the BEATS_PER_LINE=8 constant.
REQ-027 Backing storage SHALL be a single sub-module, sysbus_mem_array: one synchronous write port and one asynchronous read port, MEM_WORDS x 64.

Verification
REQ-028 Read with READ_LATENCY=4: req 0x1000, tag 0x1105; respack held at 1 -> ack in cycle 0; beats 0..7 in cycles 4..11 carry words 0x200..0x207, resptag 0x1105.
REQ-029 Write then read: write 0x2040 with data 0xA0..0xA7; next-cycle read 0x2040 -> beats 0xA0..0xA7 in order.
REQ-030 Backpressure: respack=0 for 3 cycles on beat 2 -> beat 2 data held for 4 cycles; all 8 beats delivered exactly once.
REQ-031 Unaligned and wrapped address: read 0x803F with MEM_WORDS=4096 -> same data as read 0x8000, index wraps to word 0x000.
REQ-032 Reset at beat 3 of a read -> respcyc=0 on the next cycle; a new read is acked in the first cycle after reset deasserts; previously written data is intact.
REQ-033 Busy and unsupported: reqcyc held during RD_WAIT -> reqack=0 until IDLE; a type 4'b0011 tag -> acked, no response, state stays IDLE.
